// File: rtl/bp_pkg.sv
// Shared branch-prediction types and next-PC arithmetic used by fetch,
// branch_predictor and branch_resolve_unit.
package bp_pkg;

  localparam int BP_ADDR_W = 32;

  typedef logic [BP_ADDR_W-1:0] bp_addr_t;

  localparam bp_addr_t PC_STEP = bp_addr_t'(4);

  typedef struct packed {
    bp_addr_t pc;
    logic     pvalid;
    bp_addr_t paddr;
  } bp_entry_t;

  // Sequential fall-through wraps modulo the address width.
  function automatic bp_addr_t next_pc(input bp_addr_t pc, input logic taken,
                                       input bp_addr_t target);
    return taken ? target : pc + PC_STEP;
  endfunction

endpackage

// File: rtl/bru_fifo.sv
// In-order tracking queue of fetched predictions; flush takes priority over
// push and pop, and a push while full is accepted only alongside a pop.
module bru_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  bp_entry_t push_data,
  input  logic      pop,
  input  logic      flush,
  output logic      full,
  output logic      empty,
  output bp_entry_t head
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  bp_entry_t        mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign head  = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-side resolver: checks each resolved instruction against the
// prediction recorded at fetch, feeds the predictor and redirects on mispredict.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_fire,
  input  logic [ADDR_W-1:0] f_pc,
  input  logic              f_predict_valid,
  input  logic [ADDR_W-1:0] f_predict_addr,
  output logic              f_stall,
  input  logic              x_valid,
  input  logic [ADDR_W-1:0] x_pc,
  input  logic              x_is_branch,
  input  logic              x_taken,
  input  logic [ADDR_W-1:0] x_target,
  output logic              x_res_valid,
  output logic [ADDR_W-1:0] x_res_pc,
  output logic              x_predict_res,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              order_err,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  logic        full;
  logic        empty;
  bp_entry_t   head;
  bp_entry_t   push_entry;
  logic        resolve;
  logic        actual_taken;
  logic        mispredict;
  logic        proto_err;
  bp_addr_t    pred_next;
  bp_addr_t    act_next;

  always_comb begin
    push_entry        = '0;
    push_entry.pc     = bp_addr_t'(f_pc);
    push_entry.pvalid = f_predict_valid;
    push_entry.paddr  = bp_addr_t'(f_predict_addr);
  end

  bru_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (f_fire),
    .push_data (push_entry),
    .pop       (resolve),
    .flush     (mispredict),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign f_stall      = full;
  assign resolve      = x_valid && !empty;
  assign actual_taken = x_is_branch && x_taken;
  assign pred_next    = next_pc(head.pc, head.pvalid, head.paddr);
  assign act_next     = next_pc(bp_addr_t'(x_pc), actual_taken, bp_addr_t'(x_target));
  assign mispredict   = resolve && (ADDR_W'(pred_next) != ADDR_W'(act_next));

  // A PC mismatch still resolves against the head's prediction; it only flags.
  assign proto_err = (f_fire && full && !resolve) ||
                     (x_valid && empty) ||
                     (resolve && (ADDR_W'(head.pc) != x_pc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_res_valid    <= 1'b0;
      x_res_pc       <= '0;
      x_predict_res  <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      order_err      <= 1'b0;
      mispredict_cnt <= '0;
    end else begin
      x_res_valid    <= resolve && (x_is_branch || head.pvalid);
      redirect_valid <= mispredict;
      if (resolve) begin
        x_res_pc      <= x_pc;
        x_predict_res <= actual_taken;
      end
      if (mispredict) begin
        redirect_pc <= ADDR_W'(act_next);
        if (mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
      if (proto_err) order_err <= 1'b1;
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-side partner of branch_predictor. It records every fetched instruction's prediction in an in-order tracking queue. When execute resolves that instruction, it compares the prediction with the actual next PC. It produces the predictor update stream (x_predict_res with PC) and a redirect/flush to fetch on misprediction.

Parameters:
DEPTH, 4, tracking-queue entries (power of two, >=2)
ADDR_W, 32, PC/address width
CNT_W, 16, width of the saturating mispredict counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
f_fire  in  1  fetch issues the instruction at f_pc this cycle
f_pc  in  ADDR_W  fetched PC
f_predict_valid  in  1  predictor hit for f_pc (taken prediction)
f_predict_addr  in  ADDR_W  predicted target
f_stall  out  1  queue full; fetch must hold
x_valid  in  1  execute resolves oldest in-flight instruction
x_pc  in  ADDR_W  PC being resolved
x_is_branch  in  1  instruction is a branch
x_taken  in  1  branch actually taken
x_target  in  ADDR_W  actual branch target
x_res_valid  out  1  predictor update strobe
x_res_pc  out  ADDR_W  PC the update applies to
x_predict_res  out  1  actual taken outcome for x_res_pc
redirect_valid  out  1  one-cycle flush/redirect pulse to fetch
redirect_pc  out  ADDR_W  correct next PC
order_err  out  1  sticky protocol-error flag
mispredict_cnt  out  CNT_W  saturating mispredict count

Behaviour:
- Reset (async, rst_n=0): queue empty; all outputs 0; counter 0; order_err 0. Reset mid-operation discards all in-flight entries immediately.
- Push: f_fire && !full writes entry {pc, pvalid, paddr}. f_fire while full (f_stall=1) is ignored and sets order_err.
- f_stall = full, combinational from count.
- Resolve happens when x_valid && !empty, and pops the head entry.
  - Predicted next PC = pvalid ? paddr : pc+4.
  - Actual next PC = (x_is_branch && x_taken) ? x_target : x_pc+4. Addition wraps modulo 2^ADDR_W.
  - Mispredict when the two next PCs differ.
- Outputs are registered, so all responses appear 1 cycle after the x_valid edge.
  - x_res_valid = x_is_branch | head.pvalid; x_res_pc = x_pc; x_predict_res = x_is_branch & x_taken.
  - If head.pvalid is set on a non-branch, x_predict_res=0 so the predictor de-allocates the aliased entry.
  - On mispredict: redirect_valid=1 for exactly 1 cycle; redirect_pc = actual next PC; queue flushed to empty; mispredict_cnt +1, saturating at all-ones.
- x_pc != head.pc: order_err set; the resolve is still performed with the head's prediction.
- x_valid while empty: ignored, order_err set.
- Simultaneous push and pop, no mispredict: both occur; count unchanged (legal even when full).
- Simultaneous push and pop with mispredict: flush wins and the pushed entry is discarded.
- Pointers are log2(DEPTH)+1 bits wide and wrap; full/empty come from an MSB compare.
- order_err clears only on reset.

Decomposition:
- Shared package bp_pkg holds:
  - the entry typedef {pc, pvalid, paddr};
  - PC_STEP=4;
  - the next-PC compute function, shared with branch_predictor and fetch.
- One sub-module, bru_fifo: parameterised in-order queue with push, pop, flush, full, empty and head-data outputs.
- Compare/redirect logic and counter stay in branch_resolve_unit.

Test Plan:
- Reset, then fetch 0x1000/0x1004 (no prediction), resolve both as non-branch -> no redirect, no x_res_valid, count 0, f_stall=0 throughout.
- Fetch 0x100c with prediction 0x1014; resolve taken to 0x1014 -> next cycle x_res_valid=1, x_res_pc=0x100c, x_predict_res=1, no redirect.
- Fetch 0x1014 with no prediction, then 0x1018/0x101c; resolve 0x1014 taken to 0x1000:
  - next cycle redirect_valid=1 for 1 cycle, redirect_pc=0x1000;
  - queue empty, younger 0x1018/0x101c dropped, mispredict_cnt=1.
- Fetch 0x1008 predicted 0x1010, resolve not-taken -> redirect_pc=0x100c, x_predict_res=0; same-cycle push of 0x100c is discarded.
- Push 4 entries without resolving -> f_stall=1; 5th f_fire sets order_err. Push and pop in the same cycle while full -> count stays 4.
- Resolve with x_pc=0x2000 while head is 0x1000 -> order_err=1 (sticky until reset). Force 2^CNT_W+3 mispredicts -> mispredict_cnt saturates at all-ones.
